// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_pkg
//  Description : Shared instruction word definitions for the host interface,
//                the instruction queue and the systolic-array controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_pkg;

  localparam int INSTR_W = 64;

  typedef logic [INSTR_W-1:0] instr_t;

endpackage : instr_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ptr
//  Description : Queue pointer register that wraps from DEPTH-1 back to 0,
//                so DEPTH need not be a power of two. Clear beats increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr #(
  parameter int DEPTH = 64,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Next pointer: clear to zero, or step with wrap at the last entry.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  // Pointer register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fifo
//  Description : Single-clock first-word-fall-through instruction queue with
//                valid/ready on both sides, flush, occupancy count,
//                almost-full/almost-empty flags and a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fifo
  import instr_pkg::*;
#(
  parameter int DATA_W    = INSTR_W,
  parameter int DEPTH     = 64,
  parameter int AFULL_TH  = 60,
  parameter int AEMPTY_TH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              overflow_q;
  logic              overflow_d;
  logic              push;
  logic              pop;

  // Handshake status comes only from the count register, so a full queue
  // never accepts a word even when the head is being consumed.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);

  // Flush and reset both discard any transfer of the same cycle.
  assign push = in_valid & in_ready  & rst & ~flush;
  assign pop  = out_valid & out_ready & rst & ~flush;

  fifo_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_head_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (pop),
    .ptr_o (head)
  );

  fifo_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_tail_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (push),
    .ptr_o (tail)
  );

  // Storage write port; contents are intentionally left uninitialised.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail] <= in_data;
    end
  end

  // Head entry falls through combinationally.
  assign out_data = mem_q[head];

  // Next occupancy and sticky overflow.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q | (in_valid & ~in_ready);
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Occupancy and overflow registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count        = count_q;
  assign overflow     = overflow_q;
  assign almost_full  = (count_q >= CNT_W'(AFULL_TH));
  assign almost_empty = (count_q <= CNT_W'(AEMPTY_TH));

endmodule : instr_fifo
`default_nettype wire

// File: tb/tb_instr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fifo
//  Description : Self-checking bench for instr_fifo. Two instances share one
//                stimulus stream: a 64x64 queue and a 5-entry 32-bit queue.
//                Each is compared every cycle against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fifo;

  localparam int A_DEPTH = 64;
  localparam int A_AF    = 60;
  localparam int A_AE    = 2;
  localparam int B_DEPTH = 5;
  localparam int B_AF    = 4;
  localparam int B_AE    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_afull, a_aempty, a_ovf;
  logic [63:0] a_out_data;
  logic [6:0]  a_count;
  logic        b_in_ready, b_out_valid, b_afull, b_aempty, b_ovf;
  logic [31:0] b_out_data;
  logic [2:0]  b_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] qa[$];
  logic [31:0] qb[$];
  bit          ovf_a = 1'b0;
  bit          ovf_b = 1'b0;

  always #5 clk = ~clk;

  instr_fifo #(
    .DATA_W(64), .DEPTH(A_DEPTH), .AFULL_TH(A_AF), .AEMPTY_TH(A_AE)
  ) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(out_ready),
    .count(a_count), .almost_full(a_afull), .almost_empty(a_aempty),
    .overflow(a_ovf)
  );

  instr_fifo #(
    .DATA_W(32), .DEPTH(B_DEPTH), .AFULL_TH(B_AF), .AEMPTY_TH(B_AE)
  ) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data[31:0]), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready),
    .count(b_count), .almost_full(b_afull), .almost_empty(b_aempty),
    .overflow(b_ovf)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Compare every visible output of both instances against the models.
  task automatic check_all();
    check_eq("a.count",     64'(a_count),     64'(qa.size()));
    check_eq("a.in_ready",  64'(a_in_ready),  64'(qa.size() != A_DEPTH));
    check_eq("a.out_valid", 64'(a_out_valid), 64'(qa.size() != 0));
    check_eq("a.afull",     64'(a_afull),     64'(qa.size() >= A_AF));
    check_eq("a.aempty",    64'(a_aempty),    64'(qa.size() <= A_AE));
    check_eq("a.overflow",  64'(a_ovf),       64'(ovf_a));
    if (qa.size() != 0) check_eq("a.out_data", a_out_data, qa[0]);
    check_eq("b.count",     64'(b_count),     64'(qb.size()));
    check_eq("b.in_ready",  64'(b_in_ready),  64'(qb.size() != B_DEPTH));
    check_eq("b.out_valid", 64'(b_out_valid), 64'(qb.size() != 0));
    check_eq("b.afull",     64'(b_afull),     64'(qb.size() >= B_AF));
    check_eq("b.aempty",    64'(b_aempty),    64'(qb.size() <= B_AE));
    check_eq("b.overflow",  64'(b_ovf),       64'(ovf_b));
    if (qb.size() != 0) check_eq("b.out_data", 64'(b_out_data), 64'(qb[0]));
  endtask

  // Apply one clock of the queue rules to both models using held inputs.
  task automatic model_step();
    bit do_push, do_pop;
    if (!rst) begin
      qa.delete(); qb.delete();
      ovf_a = 1'b0; ovf_b = 1'b0;
      return;
    end
    if (in_valid && qa.size() == A_DEPTH) ovf_a = 1'b1;
    if (in_valid && qb.size() == B_DEPTH) ovf_b = 1'b1;
    if (flush) begin
      qa.delete(); qb.delete();
      return;
    end
    do_push = in_valid && (qa.size() < A_DEPTH);
    do_pop  = out_ready && (qa.size() > 0);
    if (do_pop)  void'(qa.pop_front());
    if (do_push) qa.push_back(in_data);
    do_push = in_valid && (qb.size() < B_DEPTH);
    do_pop  = out_ready && (qb.size() > 0);
    if (do_pop)  void'(qb.pop_front());
    if (do_push) qb.push_back(in_data[31:0]);
  endtask

  // Check at the falling edge, then let the rising edge act on the inputs.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [63:0] base);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 64'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_data = '0;
    idle();
    @(posedge clk); #1;
    // 1: reset state
    tick(); tick();
    rst = 1'b1;
    tick();

    // 2: two words, then pop them
    push_n(1, 64'h1111);
    push_n(1, 64'h2222);
    tick();
    drain(3);

    // 3: fill 64, push while full, drain in order
    push_n(64, 64'h0);
    in_valid = 1'b1; in_data = 64'hDEAD;
    tick();
    in_valid = 1'b0;
    drain(66);

    // 4: steady push and pop at occupancy 5
    push_n(5, 64'h500);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_data = {$urandom, $urandom};
      tick();
    end
    drain(8);

    // 5: flush with a simultaneous push
    push_n(10, 64'hA00);
    flush = 1'b1; in_valid = 1'b1; in_data = 64'h1234;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    push_n(1, 64'hBEEF);
    tick();
    drain(2);

    // 6: reset mid-stream
    push_n(7, 64'h700);
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = 64'h7777;
    tick();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    idle();

    // 7: small-queue fill, wrap twice, drain
    push_n(5, 64'hC0);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_data = 64'hD0 + 64'(i);
      tick();
    end
    drain(7);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 50);
      flush     = ($urandom_range(0, 99) < 2);
      rst       = ($urandom_range(0, 199) != 0);
      in_data   = {$urandom, $urandom};
      tick();
    end
    rst = 1'b1;
    idle();
    drain(70);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_instr_fifo
`default_nettype wire
